// File: rtl/helen_button_pio.sv
// rtl/helen_button_pio.sv - Avalon-MM input PIO with per-bit debounce, sticky edge capture and level irq
module helen_button_pio #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1, sync2, stable;
  logic [WIDTH-1:0] irq_mask, edge_cap;
  logic [CW-1:0]    cnt [WIDTH];

  logic             wr_en;
  logic [WIDTH-1:0] accept, rise, fall, edge_hit, clr_mask;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  assign unused_wdata = ^writedata;

  // A bit "accepts" on the cycle its counter expires; edges are reported only then.
  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++)
      accept[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_MAX);
    rise = ~stable & sync2 & accept;
    fall = stable & ~sync2 & accept;
    case (EDGE_TYPE)
      0:       edge_hit = rise;
      1:       edge_hit = fall;
      default: edge_hit = rise | fall;
    endcase
    clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      irq_mask <= '0;
      edge_cap <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
      if (wr_en && address == 2'd2) irq_mask <= writedata[WIDTH-1:0];
      // Set beats clear so an edge landing on the clearing write is not lost.
      edge_cap <= edge_hit | (edge_cap & ~clr_mask);
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = stable;
      2'd2:    readdata[WIDTH-1:0] = irq_mask;
      2'd3:    readdata[WIDTH-1:0] = edge_cap;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_cap & irq_mask);

endmodule

// File: tb/tb_helen_button_pio.sv
// tb/tb_helen_button_pio.sv - directed self-checking bench for helen_button_pio
module tb_helen_button_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  helen_button_pio #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = '0; in_port = 8'h00;
    tick(2);
    reset = 1'b0;
    rd_check("rst_data", 2'd0, 32'h0);
    rd_check("rst_dir", 2'd1, 32'h0);
    rd_check("rst_mask", 2'd2, 32'h0);
    rd_check("rst_ecap", 2'd3, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // 1: settle all-high, clear captures
    in_port = 8'hFF;
    tick(8);
    wr(2'd3, 32'hFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd_check("t1_data", 2'd0, 32'hFF);
    rd_check("t1_ecap", 2'd3, 32'h0);
    rd_check("t1_dir", 2'd1, 32'h0);
    check("t1_irq", {31'b0, irq}, 32'h0);

    // 2: debounced falling edge on bit 0 with mask bit 0
    wr(2'd2, 32'h01);
    rd_check("t2_mask", 2'd2, 32'h01);
    in_port = 8'hFE;
    tick(5);
    rd_check("t2_data_pre", 2'd0, 32'hFF);
    rd_check("t2_ecap_pre", 2'd3, 32'h0);
    check("t2_irq_pre", {31'b0, irq}, 32'h0);
    tick(1);
    rd_check("t2_data_post", 2'd0, 32'hFE);
    rd_check("t2_ecap_post", 2'd3, 32'h1);
    check("t2_irq_post", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h1);
    check("t2_irq_clr", {31'b0, irq}, 32'h0);
    rd_check("t2_ecap_clr", 2'd3, 32'h0);

    // 3: 3-cycle glitch on bit 1 never reaches stable
    in_port = 8'hFC;
    tick(3);
    in_port = 8'hFE;
    for (int k = 0; k < 8; k++) begin
      rd(2'd0, d);
      check("t3_data", d, 32'hFE);
      rd_check("t3_ecap", 2'd3, 32'h0);
      tick(1);
    end

    // 4: edge captured while masked, then unmasked
    wr(2'd2, 32'h00);
    in_port = 8'hFA;
    tick(6);
    rd_check("t4_ecap", 2'd3, 32'h4);
    check("t4_irq_masked", {31'b0, irq}, 32'h0);
    wr(2'd2, 32'h04);
    check("t4_irq_unmasked", {31'b0, irq}, 32'h1);
    wr(2'd3, 32'h04);
    check("t4_irq_clr", {31'b0, irq}, 32'h0);

    // 5: clear write coincides with capture of bit 3
    in_port = 8'hF2;
    tick(5);
    wr(2'd3, 32'h08);
    rd_check("t5_ecap", 2'd3, 32'h08);
    rd_check("t5_data", 2'd0, 32'hF2);

    // 6: reset mid-debounce with edge_cap=05, mask=FF
    in_port = 8'hFF;
    tick(8);
    wr(2'd3, 32'hFF);
    in_port = 8'hFA;
    tick(6);
    wr(2'd2, 32'hFF);
    rd_check("t6_ecap_pre", 2'd3, 32'h05);
    check("t6_irq_pre", {31'b0, irq}, 32'h1);
    in_port = 8'hEA;
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    rd_check("t6_data_rst", 2'd0, 32'h0);
    rd_check("t6_mask_rst", 2'd2, 32'h0);
    rd_check("t6_ecap_rst", 2'd3, 32'h0);
    check("t6_irq_rst", {31'b0, irq}, 32'h0);
    tick(5);
    rd_check("t6_data_pre", 2'd0, 32'h0);
    tick(1);
    rd_check("t6_data_post", 2'd0, 32'hEA);
    rd_check("t6_ecap_post", 2'd3, 32'h0);
    check("t6_irq_post", {31'b0, irq}, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
